// File: rtl/uart_pkg.sv
// Shared encodings for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Mode 3 is treated the same as "none".
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_holdreg.sv
// One-entry valid/ready holding register for received words and their status.
module uart_rx_holdreg
#(
    parameter int DBIT = 8
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            commit,
    input  logic [DBIT-1:0] word,
    input  logic            word_perr,
    input  logic            word_ferr,
    input  logic            rx_ready,
    output logic [DBIT-1:0] dout,
    output logic            rx_valid,
    output logic            parity_err,
    output logic            frame_err,
    output logic            overrun
);

    // A commit always wins; overrun flags that an unconsumed word was lost
    // and is cleared by any handshake, including one coincident with a commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout       <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (commit) begin
            dout       <= word;
            parity_err <= word_perr;
            frame_err  <= word_ferr;
            rx_valid   <= 1'b1;
            overrun    <= rx_valid && !rx_ready;
        end else if (rx_valid && rx_ready) begin
            rx_valid   <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: rx synchroniser, oversampled frame FSM with
// start-glitch rejection, optional parity, 1/2 stop bits, holding register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int OSR  = 16
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    input  logic            s_tick,
    input  logic [1:0]      parity_mode,
    input  logic            stop2,
    input  logic            rx_ready,
    output logic [DBIT-1:0] dout,
    output logic            rx_valid,
    output logic            parity_err,
    output logic            frame_err,
    output logic            overrun,
    output logic            rx_busy
);

    localparam int SW = $clog2(OSR);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [SW-1:0] S_HALF = SW'(OSR / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OSR - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic            sync1, rx_s;
    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic            c_q, c_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic [1:0]      mode_q, mode_d;
    logic            stop2_q, stop2_d;
    logic            busy_q;
    logic            commit;

    // Next-state logic; frame config is latched at start so port changes
    // mid-frame cannot corrupt the frame in flight.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        c_d     = c_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        mode_d  = mode_q;
        stop2_d = stop2_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                    mode_d  = parity_mode;
                    stop2_d = stop2;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_HALF) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        shift_d = {rx_s, shift_q[DBIT-1:1]};
                        s_d     = '0;
                        if (n_q == N_LAST) begin
                            if (par_enabled(mode_q)) begin
                                state_d = PARITY;
                            end else begin
                                state_d = STOP;
                                c_d     = 1'b0;
                            end
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        perr_d  = ((^shift_q) ^ rx_s) != (mode_q == PAR_ODD);
                        s_d     = '0;
                        c_d     = 1'b0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        ferr_d = ferr_q | ~rx_s;
                        s_d    = '0;
                        if (c_q == stop2_q) begin
                            commit  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            c_d = c_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, synchroniser and busy flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            c_q     <= 1'b0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            mode_q  <= PAR_NONE;
            stop2_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1   <= rx;
            rx_s    <= sync1;
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            c_q     <= c_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            mode_q  <= mode_d;
            stop2_q <= stop2_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign rx_busy = busy_q;

    // The last stop-bit sample is folded into ferr_d in the commit cycle.
    uart_rx_holdreg #(.DBIT(DBIT)) u_hold (
        .clk        (clk),
        .rst        (rst),
        .commit     (commit),
        .word       (shift_q),
        .word_perr  (perr_q),
        .word_ferr  (ferr_d),
        .rx_ready   (rx_ready),
        .dout       (dout),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param (DBIT=8, OSR=16, s_tick every clk).
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       s_tick = 1'b1;
    logic [1:0] parity_mode = 2'd0;
    logic       stop2 = 1'b0;
    logic       rx_ready = 1'b1;
    logic [7:0] dout;
    logic       rx_valid, parity_err, frame_err, overrun, rx_busy;

    int checks = 0;
    int errors = 0;

    int         cap_cnt = 0;
    int         busy_cnt = 0;
    logic [7:0] cap_dout = '0;
    logic       cap_perr = 1'b0;
    logic       cap_ferr = 1'b0;
    logic       cap_ovr = 1'b0;

    uart_rx_param #(.DBIT(8), .OSR(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .s_tick      (s_tick),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .rx_ready    (rx_ready),
        .dout        (dout),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    // Record each accepted word and count busy cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            cap_cnt  = cap_cnt + 1;
            cap_dout = dout;
            cap_perr = parity_err;
            cap_ferr = frame_err;
            cap_ovr  = overrun;
        end
        if (rx_busy) busy_cnt = busy_cnt + 1;
    end

    task automatic bit_out(input logic v);
        rx = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                              input logic st1, input logic two, input logic st2);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        if (par_en) bit_out(par_bit);
        bit_out(st1);
        if (two) bit_out(st2);
        rx = 1'b1;
        repeat (32) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx_valid); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", parity_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", overrun); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", rx_busy); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1();
        int c0, b0, bd;
        c0 = cap_cnt; b0 = busy_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        bd = busy_cnt - b0;
        checks++; if (cap_cnt - c0 !== 1) begin errors++; $display("FAIL 8n1_count got %0d want 1", cap_cnt - c0); end
        checks++; if (cap_dout !== 8'hA5) begin errors++; $display("FAIL 8n1_dout got %h want a5", cap_dout); end
        checks++; if (cap_perr !== 1'b0) begin errors++; $display("FAIL 8n1_perr got %b want 0", cap_perr); end
        checks++; if (cap_ferr !== 1'b0) begin errors++; $display("FAIL 8n1_ferr got %b want 0", cap_ferr); end
        checks++; if (cap_ovr !== 1'b0) begin errors++; $display("FAIL 8n1_ovr got %b want 0", cap_ovr); end
        checks++; if (bd < 148 || bd > 156) begin errors++; $display("FAIL 8n1_busy_len got %0d want 152", bd); end
    endtask

    task automatic test_parity();
        int c0;
        c0 = cap_cnt;
        parity_mode = 2'd1;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (cap_dout !== 8'h03) begin errors++; $display("FAIL par_even1_dout got %h want 03", cap_dout); end
        checks++; if (cap_perr !== 1'b1) begin errors++; $display("FAIL par_even1_perr got %b want 1", cap_perr); end
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (cap_perr !== 1'b0) begin errors++; $display("FAIL par_even0_perr got %b want 0", cap_perr); end
        parity_mode = 2'd2;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (cap_perr !== 1'b0) begin errors++; $display("FAIL par_odd1_perr got %b want 0", cap_perr); end
        checks++; if (cap_cnt - c0 !== 3) begin errors++; $display("FAIL par_count got %0d want 3", cap_cnt - c0); end
        parity_mode = 2'd0;
    endtask

    task automatic test_stop2();
        int c0;
        c0 = cap_cnt;
        stop2 = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (cap_dout !== 8'h3C) begin errors++; $display("FAIL stop2_bad_dout got %h want 3c", cap_dout); end
        checks++; if (cap_ferr !== 1'b1) begin errors++; $display("FAIL stop2_bad_ferr got %b want 1", cap_ferr); end
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++; if (cap_dout !== 8'hC3) begin errors++; $display("FAIL stop2_ok_dout got %h want c3", cap_dout); end
        checks++; if (cap_ferr !== 1'b0) begin errors++; $display("FAIL stop2_ok_ferr got %b want 0", cap_ferr); end
        checks++; if (cap_cnt - c0 !== 2) begin errors++; $display("FAIL stop2_count got %0d want 2", cap_cnt - c0); end
        stop2 = 1'b0;
    endtask

    task automatic test_glitch();
        int c0, b0, bd;
        c0 = cap_cnt; b0 = busy_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        bd = busy_cnt - b0;
        checks++; if (cap_cnt !== c0) begin errors++; $display("FAIL glitch_count got %0d want %0d", cap_cnt, c0); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got %b want 0", rx_valid); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", rx_busy); end
        checks++; if (bd < 1 || bd > 16) begin errors++; $display("FAIL glitch_busy_len got %0d want 1..16", bd); end
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid got %b want 1", rx_valid); end
        checks++; if (dout !== 8'h11) begin errors++; $display("FAIL ovr_first_dout got %h want 11", dout); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_ovr got %b want 0", overrun); end
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (dout !== 8'h22) begin errors++; $display("FAIL ovr_second_dout got %h want 22", dout); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_second_valid got %b want 1", rx_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_second_ovr got %b want 1", overrun); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_hs_valid got %b want 0", rx_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_hs_ovr got %b want 0", overrun); end
        @(negedge clk);
        rx_ready = 1'b1;
    endtask

    task automatic test_reset_midframe();
        int c0;
        logic [7:0] d;
        d  = 8'hF3;
        c0 = cap_cnt;
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(d[i]);
        rx = d[4];
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midrst_dout got %h want 00", dout); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", rx_valid); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", rx_busy); end
        checks++; if ({parity_err, frame_err, overrun} !== 3'b000) begin
            errors++; $display("FAIL midrst_flags got %b want 000", {parity_err, frame_err, overrun});
        end
        rst = 1'b1;
        repeat (7) @(negedge clk);
        for (int i = 5; i < 8; i++) bit_out(d[i]);
        bit_out(1'b1);
        repeat (32) @(negedge clk);
        checks++; if (cap_cnt !== c0) begin errors++; $display("FAIL midrst_nocommit got %0d want %0d", cap_cnt, c0); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid_after got %b want 0", rx_valid); end
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (cap_cnt - c0 !== 1) begin errors++; $display("FAIL post_rst_count got %0d want 1", cap_cnt - c0); end
        checks++; if (cap_dout !== 8'h5A) begin errors++; $display("FAIL post_rst_dout got %h want 5a", cap_dout); end
        checks++; if ({cap_perr, cap_ferr, cap_ovr} !== 3'b000) begin
            errors++; $display("FAIL post_rst_flags got %b want 000", {cap_perr, cap_ferr, cap_ovr});
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop2();
        test_glitch();
        test_overrun();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the next generation of the team's fixed 8N1 receiver. It supports configurable data width and oversampling ratio, runtime-selectable parity and stop-bit count, start-bit glitch rejection, and an rx input synchroniser. Received words go to a one-entry valid/ready holding register carrying per-word parity, framing and overrun status. It sits between the shared baud-tick generator (s_tick source) and any byte-consuming client.

Parameters:
DBIT, 8, data bits per frame; legal 5..9; also the width of dout.
OSR, 16, s_tick pulses per bit period; even, at least 4.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous and active-low (asserted when 0, sampled on rising clk)
rx  in  1  serial line, asynchronous, idle high
s_tick  in  1  oversample strobe, one clk wide
parity_mode  in  2  0 = none, 1 = even, 2 = odd, 3 = none
stop2  in  1  0 = one stop bit, 1 = two stop bits
rx_ready  in  1  consumer accepts dout this cycle
dout  out  DBIT  received word, LSB first on the line
rx_valid  out  1  dout holds an unconsumed word
parity_err  out  1  parity mismatch for the word in dout
frame_err  out  1  a stop bit was sampled 0 for the word in dout
overrun  out  1  an unconsumed word was overwritten
rx_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0 at a clk edge):
  - FSM goes to IDLE; all counters and the shift register clear.
  - The two synchroniser flops are set to 1.
  - Outputs: dout=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, rx_busy=0.
  - Reset mid-frame abandons the frame; nothing is committed.
- Synchroniser: rx passes through 2 flops to give rx_s. All sampling uses rx_s, so the added latency is 2 clk.
- Counters:
  - s counts s_tick pulses, 0..OSR-1.
  - n counts data bits, 0..DBIT-1.
  - c counts stop bits, 0..1.
  - All state advances happen only on clk cycles where s_tick=1, except IDLE->START.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On rx_s=0: go to START, s=0, and latch parity_mode and stop2 into the frame config.
  - Config port changes mid-frame have no effect.
- START, on tick:
  - If s=OSR/2-1 and rx_s=0: go to DATA, s=0, n=0.
  - If s=OSR/2-1 and rx_s=1: glitch; go to IDLE with nothing committed.
  - Otherwise s++.
- DATA, on tick with s=OSR-1:
  - shift <= {rx_s, shift[DBIT-1:1]}, s=0.
  - If n=DBIT-1: go to PARITY when parity is enabled, else STOP with c=0.
  - Otherwise n++.
  - On other ticks, s++.
- PARITY, on tick with s=OSR-1:
  - Capture perr = (^shift ^ rx_s) != odd, where odd=1 for mode 2.
  - s=0, c=0, go to STOP.
  - When parity is disabled, perr=0.
- STOP, on tick with s=OSR-1:
  - ferr |= ~rx_s, s=0.
  - If c=stop2 (latched): commit, then go to IDLE.
  - Otherwise c++.
- Commit (single clk):
  - dout<=shift, parity_err<=perr, frame_err<=ferr, rx_valid<=1.
  - ferr is cleared at frame start.
  - After a frame error the FSM returns to IDLE anyway. A held-low line then restarts START detection and re-commits with frame_err set.
- Handshake: rx_valid&&rx_ready with no commit in the same cycle gives rx_valid<=0 and overrun<=0.
- Commit while rx_valid=1 and rx_ready=0: the new word overwrites dout and its flags; overrun<=1, which stays set until the next handshake.
- Commit and handshake in the same cycle: the new word loads, rx_valid stays 1, overrun<=0.
- Error flags describe the word currently in dout. They are not sticky across words.
- rx_busy is registered and equals (state != IDLE).

Decomposition:
- Shared package uart_pkg:
  - state encoding constants IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3 bits);
  - parity mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
- One natural sub-module: uart_rx_holdreg. It holds dout and the flags, implements the commit/handshake/overrun rules, and is verifiable standalone.
- The synchroniser stays inline.

Test Plan (all with DBIT=8, OSR=16, s_tick=1 every clk, rx_ready=1 unless stated):
- 8N1 frame, 0xA5 -> one rx_valid pulse; dout=0xA5; parity_err=frame_err=overrun=0; rx_busy high for roughly 16*9+8 clk.
- Even parity, data 0x03 sent with parity bit 1 -> dout=0x03, parity_err=1. The same data with parity bit 0 -> parity_err=0. Odd mode with parity bit 1 -> parity_err=0.
- 8N2 frame with the second stop bit driven 0 -> frame_err=1, dout=transmitted byte. With both stop bits 1 -> frame_err=0.
- rx low for 4 s_ticks then high -> FSM returns to IDLE from START; rx_valid stays 0; rx_busy falls.
- rx_ready=0, frames 0x11 then 0x22 -> after the second frame dout=0x22, rx_valid=1, overrun=1. Then rx_ready=1 for one clk -> rx_valid=0, overrun=0.
- rst=0 during data bit 4 of a frame -> all outputs 0 on the next clk and no commit. The next clean frame 0x5A is received with no errors.
